// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: op-code constants, FSM state encoding and op classification.
package alu_seq_pkg;

    localparam logic [3:0] OpAnd     = 4'b0000;
    localparam logic [3:0] OpOr      = 4'b0001;
    localparam logic [3:0] OpAdd     = 4'b0010;
    localparam logic [3:0] OpSll     = 4'b0011;
    localparam logic [3:0] OpSrl     = 4'b0100;
    localparam logic [3:0] OpSra     = 4'b0101;
    localparam logic [3:0] OpSub     = 4'b0110;
    localparam logic [3:0] OpSlt     = 4'b0111;
    localparam logic [3:0] OpXor     = 4'b1000;
    localparam logic [3:0] OpNor     = 4'b1001;
    localparam logic [3:0] OpMult    = 4'b1010;
    localparam logic [3:0] OpSltu    = 4'b1011;
    localparam logic [3:0] OpMultu   = 4'b1100;
    localparam logic [3:0] OpDiv     = 4'b1101;
    localparam logic [3:0] OpDivu    = 4'b1110;
    localparam logic [3:0] OpIllegal = 4'b1111;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    typedef enum logic [1:0] {ClsSingle, ClsMul, ClsDiv, ClsIllegal} op_class_e;

    function automatic op_class_e classify_op(input logic [3:0] op);
        op_class_e cls;
        unique case (op)
            OpMult, OpMultu: cls = ClsMul;
            OpDiv, OpDivu:   cls = ClsDiv;
            OpIllegal:       cls = ClsIllegal;
            default:         cls = ClsSingle;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative magnitude multiplier / restoring divider sharing one (WIDTH+1)-bit adder.
// The first step runs on the start cycle, so done rises WIDTH-1 cycles after start.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, div_q;

    logic [WIDTH-1:0] cur_hi, cur_lo, cur_b, step_hi, step_lo;
    logic             cur_div;
    logic [WIDTH:0]   add_a, add_b, sum;

    always_comb begin
        cur_hi  = start ? '0 : hi_q;
        cur_lo  = start ? a_mag : lo_q;
        cur_b   = start ? b_mag : b_q;
        cur_div = start ? is_div : div_q;

        if (cur_div) begin
            add_a = {cur_hi, cur_lo[WIDTH-1]};
            add_b = ~{1'b0, cur_b};
        end else begin
            add_a = {1'b0, cur_hi};
            add_b = cur_lo[0] ? {1'b0, cur_b} : '0;
        end
        sum = add_a + add_b + {{WIDTH{1'b0}}, cur_div};

        if (cur_div) begin
            // Negative trial difference: keep the shifted remainder, quotient bit 0
            if (sum[WIDTH]) begin
                step_hi = add_a[WIDTH-1:0];
                step_lo = {cur_lo[WIDTH-2:0], 1'b0};
            end else begin
                step_hi = sum[WIDTH-1:0];
                step_lo = {cur_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], cur_lo[WIDTH-1:1]};
        end
    end

    assign done   = busy_q && (cnt_q == CNT_W'(WIDTH));
    assign res_hi = hi_q;
    assign res_lo = lo_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else if (start) begin
            hi_q   <= step_hi;
            lo_q   <= step_lo;
            b_q    <= b_mag;
            div_q  <= is_div;
            cnt_q  <= CNT_W'(1);
            busy_q <= 1'b1;
        end else if (done) begin
            busy_q <= 1'b0;
        end else if (busy_q) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle EX-stage ALU behind valid/ready, with iterative mul/div giving HI/LO.
// Signed add/sub overflow detection is built only when ALU_SEQ_OVERFLOW_EN is defined.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned CNT_W   = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               zero,
    output logic               div_by_zero,
    output logic               illegal_op,
    output logic               overflow
);

    state_e    state_q, state_d;
    op_class_e op_cls;
    logic      accept, iter_start, iter_done, b_zero, signed_op, a_neg, b_neg;

    logic [WIDTH-1:0]   a_mag, b_mag, iter_hi, iter_lo, alu_out, add_res, sub_res;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic             zero_q, zero_d, dbz_q, dbz_d, ill_q, ill_d;
    logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;

    assign op_cls    = classify_op(op);
    assign accept    = in_valid && in_ready;
    assign b_zero    = (op_b == '0);
    assign signed_op = (op == OpMult) || (op == OpDiv);
    assign a_neg     = signed_op && op_a[WIDTH-1];
    assign b_neg     = signed_op && op_b[WIDTH-1];
    assign a_mag     = a_neg ? -op_a : op_a;
    assign b_mag     = b_neg ? -op_b : op_b;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (op_cls)
                        ClsMul:  state_d = StMul;
                        ClsDiv:  state_d = b_zero ? StDone : StDiv;
                        default: state_d = StDone;
                    endcase
                end
            end
            StMul, StDiv: if (iter_done) state_d = StDone;
            StDone:       if (out_ready) state_d = StIdle;
            default:      state_d = StIdle;
        endcase
    end

    // Outputs; in_ready is held low while reset is asserted
    always_comb begin
        in_ready   = rst_n && (state_q == StIdle);
        out_valid  = (state_q == StDone);
        iter_start = accept && ((op_cls == ClsMul) || ((op_cls == ClsDiv) && !b_zero));
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .is_div (op_cls == ClsDiv),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .done   (iter_done),
        .res_hi (iter_hi),
        .res_lo (iter_lo)
    );

    always_comb begin
        add_res = op_a + op_b;
        sub_res = op_a - op_b;
        unique case (op)
            OpAnd:   alu_out = op_a & op_b;
            OpOr:    alu_out = op_a | op_b;
            OpAdd:   alu_out = add_res;
            OpSll:   alu_out = op_b << shamt;
            OpSrl:   alu_out = op_b >> shamt;
            OpSra:   alu_out = $unsigned($signed(op_b) >>> shamt);
            OpSub:   alu_out = sub_res;
            OpSlt:   alu_out = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OpXor:   alu_out = op_a ^ op_b;
            OpNor:   alu_out = ~(op_a | op_b);
            OpSltu:  alu_out = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            default: alu_out = '0;
        endcase
    end

    // Sign fix-up: quotient/product take the xor of operand signs, remainder the dividend sign
    assign prod_fix = neg_lo_q ? -{iter_hi, iter_lo} : {iter_hi, iter_lo};
    assign quo_fix  = neg_lo_q ? -iter_lo : iter_lo;
    assign rem_fix  = neg_hi_q ? -iter_hi : iter_hi;

    always_comb begin
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        ill_d       = ill_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        if (accept) begin
            result_d    = '0;
            result_hi_d = '0;
            zero_d      = (op_a == op_b);
            dbz_d       = 1'b0;
            ill_d       = 1'b0;
            neg_lo_d    = a_neg ^ b_neg;
            neg_hi_d    = a_neg;
            unique case (op_cls)
                ClsSingle:  result_d = alu_out;
                ClsIllegal: ill_d = 1'b1;
                ClsDiv: begin
                    if (b_zero) begin
                        result_d    = '1;
                        result_hi_d = op_a;
                        dbz_d       = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (iter_done && (state_q == StMul)) begin
            {result_hi_d, result_d} = prod_fix;
        end else if (iter_done && (state_q == StDiv)) begin
            result_d    = quo_fix;
            result_hi_d = rem_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
        end else begin
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            ill_q       <= ill_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
        end
    end

    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

`ifdef ALU_SEQ_OVERFLOW_EN
    logic ovf_q, ovf_calc;

    // Sub flips op_b's sign, so overflow needs the operand signs to differ
    always_comb begin
        ovf_calc = 1'b0;
        if (op == OpAdd) begin
            ovf_calc = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_res[WIDTH-1] != op_a[WIDTH-1]);
        end else if (op == OpSub) begin
            ovf_calc = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_res[WIDTH-1] != op_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      ovf_q <= 1'b0;
        else if (accept) ovf_q <= ovf_calc;
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq plus hand-written stall and mid-operation reset sequences.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 32;
`ifdef ALU_SEQ_OVERFLOW_EN
    localparam bit OvfOn = 1'b1;
`else
    localparam bit OvfOn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   op;
    logic [W-1:0] op_a, op_b, result, result_hi;
    logic [4:0]   shamt;
    logic         zero, div_by_zero, illegal_op, overflow;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .op_a        (op_a),
        .op_b        (op_b),
        .shamt       (shamt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [4:0]   sh;
        logic [W-1:0] res, hi;
        logic         z, dbz, ill, ovf;
        int           lat;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[22];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [4:0] sh, input logic [W-1:0] res,
                                input logic [W-1:0] hi, input logic z, input logic dbz,
                                input logic ill, input logic ovf, input int lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.sh = sh; v.res = res; v.hi = hi;
        v.z = z; v.dbz = dbz; v.ill = ill; v.ovf = ovf; v.lat = lat;
        return v;
    endfunction

    task automatic do_op(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        op = v.op; op_a = v.a; op_b = v.b; shamt = v.sh; in_valid = 1'b1;
        check($sformatf("v%0d.in_ready", idx), in_ready, 1);
        @(posedge clk); #1;
        // Scramble inputs after accept: results must come from captured operands
        in_valid = 1'b0; op = OpAnd; op_a = ~v.a; op_b = v.b ^ 32'h5A5A_5A5A; shamt = ~v.sh;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("v%0d.latency", idx), lat, v.lat);
        check($sformatf("v%0d.result", idx), result, v.res);
        check($sformatf("v%0d.result_hi", idx), result_hi, v.hi);
        check($sformatf("v%0d.zero", idx), zero, v.z);
        check($sformatf("v%0d.div_by_zero", idx), div_by_zero, v.dbz);
        check($sformatf("v%0d.illegal_op", idx), illegal_op, v.ill);
        check($sformatf("v%0d.overflow", idx), overflow, v.ovf);
        @(posedge clk); #1;
        check($sformatf("v%0d.consumed", idx), out_valid, 0);
        check($sformatf("v%0d.ready_again", idx), in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int stray;

        vecs[0]  = mk(OpAdd,     32'h7FFF_FFFF, 32'h1,          0,  32'h8000_0000, 0, 0, 0, 0, OvfOn, 1);
        vecs[1]  = mk(OpSra,     32'h0,         32'hF000_0000,  4,  32'hFF00_0000, 0, 0, 0, 0, 0, 1);
        vecs[2]  = mk(OpSrl,     32'h0,         32'hF000_0000,  4,  32'h0F00_0000, 0, 0, 0, 0, 0, 1);
        vecs[3]  = mk(OpSlt,     32'hFFFF_FFFF, 32'h1,          0,  32'h1,         0, 0, 0, 0, 0, 1);
        vecs[4]  = mk(OpSltu,    32'hFFFF_FFFF, 32'h1,          0,  32'h0,         0, 0, 0, 0, 0, 1);
        vecs[5]  = mk(OpAnd,     32'hF0F0_F0F0, 32'hFF00_FF00,  0,  32'hF000_F000, 0, 0, 0, 0, 0, 1);
        vecs[6]  = mk(OpOr,      32'hF0F0_F0F0, 32'hFF00_FF00,  0,  32'hFFF0_FFF0, 0, 0, 0, 0, 0, 1);
        vecs[7]  = mk(OpXor,     32'hF0F0_F0F0, 32'hFF00_FF00,  0,  32'h0FF0_0FF0, 0, 0, 0, 0, 0, 1);
        vecs[8]  = mk(OpNor,     32'hF0F0_F0F0, 32'hFF00_FF00,  0,  32'h000F_000F, 0, 0, 0, 0, 0, 1);
        vecs[9]  = mk(OpSub,     32'h5,         32'h5,          0,  32'h0,         0, 1, 0, 0, 0, 1);
        vecs[10] = mk(OpSub,     32'h8000_0000, 32'h1,          0,  32'h7FFF_FFFF, 0, 0, 0, 0, OvfOn, 1);
        vecs[11] = mk(OpSll,     32'h0,         32'h1,          31, 32'h8000_0000, 0, 0, 0, 0, 0, 1);
        vecs[12] = mk(OpMult,    32'hFFFF_FFFD, 32'h5,          0,  32'hFFFF_FFF1, 32'hFFFF_FFFF,
                      0, 0, 0, 0, W + 1);
        vecs[13] = mk(OpMultu,   32'hFFFF_FFFF, 32'h2,          0,  32'hFFFF_FFFE, 32'h1,
                      0, 0, 0, 0, W + 1);
        vecs[14] = mk(OpDiv,     32'hFFFF_FFF9, 32'h2,          0,  32'hFFFF_FFFD, 32'hFFFF_FFFF,
                      0, 0, 0, 0, W + 1);
        vecs[15] = mk(OpDivu,    32'h7,         32'h0,          0,  32'hFFFF_FFFF, 32'h7,
                      0, 1, 0, 0, 1);
        vecs[16] = mk(OpDiv,     32'h8000_0000, 32'hFFFF_FFFF,  0,  32'h8000_0000, 32'h0,
                      0, 0, 0, 0, W + 1);
        vecs[17] = mk(OpDivu,    32'd100,       32'd7,          0,  32'd14,        32'd2,
                      0, 0, 0, 0, W + 1);
        vecs[18] = mk(OpDiv,     32'h7,         32'hFFFF_FFFE,  0,  32'hFFFF_FFFD, 32'h1,
                      0, 0, 0, 0, W + 1);
        vecs[19] = mk(OpMult,    32'h8000_0000, 32'h8000_0000,  0,  32'h0,         32'h4000_0000,
                      1, 0, 0, 0, W + 1);
        vecs[20] = mk(OpIllegal, 32'h3,         32'h3,          0,  32'h0,         32'h0, 1, 0, 1, 0, 1);
        vecs[21] = mk(OpAdd,     32'hFFFF_FFFF, 32'h1,          0,  32'h0,         32'h0, 0, 0, 0, 0, 1);

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; op_a = '0; op_b = '0; shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", in_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.result", result, 0);
        check("rst.result_hi", result_hi, 0);
        check("rst.flags", {zero, div_by_zero, illegal_op, overflow}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst.ready_after", in_ready, 1);

        for (int i = 0; i < 22; i++) do_op(vecs[i], i);

        // Stall in DONE with out_ready low; concurrent requests must be ignored
        @(negedge clk);
        out_ready = 1'b0; op = OpMult; op_a = 32'hFFFF_FFFD; op_b = 32'h5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("stall.latency", lat, W + 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; op = OpAdd; op_a = 32'h1; op_b = 32'h1;
            @(posedge clk); #1;
            check($sformatf("stall%0d.out_valid", k), out_valid, 1);
            check($sformatf("stall%0d.in_ready", k), in_ready, 0);
            check($sformatf("stall%0d.result", k), result, 32'hFFFF_FFF1);
            check($sformatf("stall%0d.result_hi", k), result_hi, 32'hFFFF_FFFF);
            check($sformatf("stall%0d.zero", k), zero, 0);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall.release_valid", out_valid, 0);
        check("stall.release_ready", in_ready, 1);
        @(posedge clk); #1;
        check("stall.no_phantom", out_valid, 0);

        // Reset while the multiplier is mid-iteration
        @(negedge clk);
        op = OpMult; op_a = 32'h0001_2345; op_b = 32'h0001_2345; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("midrst.in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        check("midrst.out_valid", out_valid, 0);
        check("midrst.result", result, 0);
        check("midrst.result_hi", result_hi, 0);
        check("midrst.flags", {zero, div_by_zero, illegal_op, overflow}, 0);
        @(negedge clk); rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        check("midrst.no_stale_result", stray, 0);
        do_op(vecs[20], 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
